// File: rtl/rc_charge_timer.sv
// rc_charge_timer
// Drives an RC load and measures how long the comparator takes to rise.
// Each measurement discharges the node, then charges it. It counts charge
// cycles until the deglitched comparator goes high.
//
// Ports:
//   clk        clock
//   rst        synchronous reset, active-high
//   start      one-cycle request to run a measurement (ignored unless idle)
//   cmp_in     asynchronous comparator output (high: vout above threshold)
//   drive_out  RC supply drive, 1 = charge, 0 = discharge
//   busy       measurement in progress
//   done       one-cycle pulse, result valid
//   count      charge cycles measured, held until the next done
//   timeout    last measurement reached MAX_COUNT, held until next start
//   stuck      comparator high at end of discharge, held until next start
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | node discharged, waiting for start
// DISCHARGE  | settle timer running with drive low, stuck check on expiry
// CHARGE     | drive high, chg_cnt counting, waiting for deglitched crossing
// DONE       | single cycle with done high, then back to IDLE
module rc_charge_timer #(
   parameter int CNT_W         = 16,
   parameter int SETTLE_CYCLES = 64,
   parameter int DEGLITCH      = 2,
   parameter int MAX_COUNT     = 65535
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             cmp_in,
   output logic             drive_out,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] count,
   output logic             timeout,
   output logic             stuck
);

   localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   typedef enum logic [1:0] {S_IDLE, S_DISCHARGE, S_CHARGE, S_DONE} state_t;

   state_t             state_q, state_d;
   logic               sync1_q, sync2_q;
   logic [SET_W-1:0]   settle_q, settle_d;
   logic [CNT_W-1:0]   chg_cnt_q, chg_cnt_d;
   logic [3:0]         hi_run_q, hi_run_d;
   logic               drive_q, drive_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               timeout_q, timeout_d;
   logic               stuck_q, stuck_d;
   logic               crossing;

   // Settle timer counts down from SETTLE_CYCLES-1, so the last discharge
   // cycle is the one where it reads zero.
   always_comb begin
      state_d   = state_q;
      settle_d  = settle_q;
      chg_cnt_d = chg_cnt_q;
      hi_run_d  = hi_run_q;
      drive_d   = drive_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      count_d   = count_q;
      timeout_d = timeout_q;
      stuck_d   = stuck_q;
      crossing  = sync2_q && (hi_run_q == 4'(DEGLITCH - 1));

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d   = S_DISCHARGE;
               busy_d    = 1'b1;
               timeout_d = 1'b0;
               stuck_d   = 1'b0;
               settle_d  = SET_W'(SETTLE_CYCLES - 1);
            end
         end
         S_DISCHARGE: begin
            if (settle_q == '0) begin
               if (sync2_q) begin
                  // Comparator never dropped: report without charging.
                  state_d = S_IDLE;
                  stuck_d = 1'b1;
                  count_d = '0;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
               end else begin
                  state_d   = S_CHARGE;
                  drive_d   = 1'b1;
                  chg_cnt_d = '0;
                  hi_run_d  = '0;
               end
            end else begin
               settle_d = settle_q - 1'b1;
            end
         end
         S_CHARGE: begin
            if (!sync2_q)
               hi_run_d = '0;
            else if (hi_run_q != 4'hF)
               hi_run_d = hi_run_q + 1'b1;

            // Crossing is tested first so it wins over a same-cycle timeout.
            if (crossing || (chg_cnt_q == CNT_W'(MAX_COUNT))) begin
               state_d   = S_DONE;
               count_d   = chg_cnt_q;
               timeout_d = !crossing;
               done_d    = 1'b1;
               busy_d    = 1'b0;
               drive_d   = 1'b0;
            end else begin
               chg_cnt_d = chg_cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         settle_q  <= '0;
         chg_cnt_q <= '0;
         hi_run_q  <= '0;
         drive_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         count_q   <= '0;
         timeout_q <= 1'b0;
         stuck_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         sync1_q   <= cmp_in;
         sync2_q   <= sync1_q;
         settle_q  <= settle_d;
         chg_cnt_q <= chg_cnt_d;
         hi_run_q  <= hi_run_d;
         drive_q   <= drive_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         count_q   <= count_d;
         timeout_q <= timeout_d;
         stuck_q   <= stuck_d;
      end
   end

   assign drive_out = drive_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign count     = count_q;
   assign timeout   = timeout_q;
   assign stuck     = stuck_q;

endmodule

// File: tb/tb_rc_charge_timer.sv
// tb_rc_charge_timer
// Directed vector table and random measurements for rc_charge_timer.
// Timeline per measurement: cycle 0 carries start, cycles 1..S are
// discharge, and charge cycle c is timeline cycle S+1+c.
module tb_rc_charge_timer;
   localparam int CNT_W = 16;
   localparam int S     = 64;
   localparam int DG    = 2;
   localparam int MAXC  = 500;
   localparam int NT    = 700;

   logic             clk = 1'b0;
   logic             rst, start, cmp_in;
   logic             drive_out, busy, done, timeout, stuck;
   logic [CNT_W-1:0] count;

   int n_checks = 0;
   int n_errors = 0;

   bit w  [NT];
   bit st [NT];

   always #5 clk = ~clk;

   rc_charge_timer #(
      .CNT_W(CNT_W), .SETTLE_CYCLES(S), .DEGLITCH(DG), .MAX_COUNT(MAXC)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .cmp_in(cmp_in),
      .drive_out(drive_out), .busy(busy), .done(done), .count(count),
      .timeout(timeout), .stuck(stuck)
   );

   typedef struct {
      string name;
      int    rise_c;
      int    glitch_c;
      bit    high_all;
      int    extra_c;
      int    exp_cnt;
      bit    exp_to;
      bit    exp_stk;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         if (n_errors <= 30)
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit sync_at(input int t);
      return (t >= 2) ? w[t-2] : 1'b0;
   endfunction

   // Reference: stuck if the synchronized comparator is high in the last
   // discharge cycle; otherwise the first charge cycle that ends a run of
   // DG synchronized-high charge cycles, else timeout at MAXC.
   task automatic model(output int cnt, output bit to, output bit stk);
      int run;
      cnt = 0; to = 0; stk = 0; run = 0;
      if (sync_at(S)) begin
         stk = 1;
         return;
      end
      for (int c = 0; c <= MAXC; c++) begin
         run = sync_at(S + 1 + c) ? run + 1 : 0;
         if (run >= DG) begin
            cnt = c;
            return;
         end
      end
      cnt = MAXC;
      to  = 1;
   endtask

   function automatic int done_cycle(input int ec, input bit estk);
      return estk ? S + 1 : S + 2 + ec;
   endfunction

   task automatic clear_wave();
      for (int t = 0; t < NT; t++) begin
         w[t]  = 1'b0;
         st[t] = 1'b0;
      end
      st[0] = 1'b1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         start  = 1'b0;
         cmp_in = 1'b0;
      end
   endtask

   task automatic run_meas(input string name, input int ec, input bit eto, input bit estk);
      int td;
      bit eb, ed;
      td = done_cycle(ec, estk);
      for (int t = 0; t <= td + 2; t++) begin
         @(posedge clk); #1;
         start  = st[t];
         cmp_in = w[t];
         @(negedge clk);
         eb = (t >= 1) && (t < td);
         ed = !estk && (t >= S + 1) && (t <= S + 1 + ec);
         chk({name, ".busy"},  busy,      eb);
         chk({name, ".drive"}, drive_out, ed);
         chk({name, ".done"},  done,      t == td);
         if (t == td || t == td + 2) begin
            chk({name, ".count"},   count,   ec);
            chk({name, ".timeout"}, timeout, eto);
            chk({name, ".stuck"},   stuck,   estk);
         end
      end
      idle(3);
   endtask

   task automatic build_wave(input int rise_c, input int glitch_c, input bit high_all);
      clear_wave();
      for (int t = 0; t < NT; t++) begin
         if (high_all) w[t] = 1'b1;
         if (rise_c >= 0 && t >= S + 1 + rise_c) w[t] = 1'b1;
      end
      if (glitch_c >= 0) w[S + 1 + glitch_c] = 1'b1;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int ec, td, lim, mode, th;
      bit eto, estk;

      vecs[0] = '{"nominal",   100, -1, 1'b0, -1, 103, 1'b0, 1'b0};
      vecs[1] = '{"glitch",    200, 40, 1'b0, -1, 203, 1'b0, 1'b0};
      vecs[2] = '{"timeout",    -1, -1, 1'b0, -1, 500, 1'b1, 1'b0};
      vecs[3] = '{"stuck",      -1, -1, 1'b1, -1,   0, 1'b0, 1'b1};
      vecs[4] = '{"start_ign", 100, -1, 1'b0, 10, 103, 1'b0, 1'b0};
      vecs[5] = '{"rise0",       0, -1, 1'b0, -1,   3, 1'b0, 1'b0};
      vecs[6] = '{"tie",       497, -1, 1'b0, -1, 500, 1'b0, 1'b0};
      vecs[7] = '{"late",      498, -1, 1'b0, -1, 500, 1'b1, 1'b0};
      vecs[8] = '{"pulse2",     -1, -1, 1'b0, -1,  43, 1'b0, 1'b0};

      rst = 1'b1; start = 1'b0; cmp_in = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset.drive", drive_out, 0);
      chk("reset.busy", busy, 0);
      chk("reset.done", done, 0);
      chk("reset.count", count, 0);
      chk("reset.timeout", timeout, 0);
      chk("reset.stuck", stuck, 0);

      // start together with rst must not launch a measurement
      @(posedge clk); #1 rst = 1'b1; start = 1'b1;
      @(posedge clk); #1 rst = 1'b0; start = 1'b0;
      @(negedge clk);
      chk("rst_start.busy", busy, 0);
      @(negedge clk);
      chk("rst_start.busy2", busy, 0);
      idle(2);

      for (int i = 0; i < 9; i++) begin
         build_wave(vecs[i].rise_c, vecs[i].glitch_c, vecs[i].high_all);
         if (i == 8) begin
            w[S + 1 + 40] = 1'b1;
            w[S + 1 + 41] = 1'b1;
         end
         if (vecs[i].extra_c >= 0) begin
            st[S + 1 + vecs[i].extra_c] = 1'b1;
            st[done_cycle(vecs[i].exp_cnt, vecs[i].exp_stk)] = 1'b1;
         end
         run_meas(vecs[i].name, vecs[i].exp_cnt, vecs[i].exp_to, vecs[i].exp_stk);
      end

      // reset in the middle of charging, then a clean measurement
      build_wave(-1, -1, 1'b0);
      for (int t = 0; t <= S + 51; t++) begin
         @(posedge clk); #1;
         start  = st[t];
         cmp_in = w[t];
         rst    = (t == S + 51);
      end
      @(negedge clk);
      chk("midrst.drive_before", drive_out, 1);
      chk("midrst.count_before", count, 43);
      @(posedge clk); #1 rst = 1'b0; start = 1'b0;
      @(negedge clk);
      chk("midrst.drive", drive_out, 0);
      chk("midrst.busy", busy, 0);
      chk("midrst.done", done, 0);
      chk("midrst.count", count, 0);
      chk("midrst.timeout", timeout, 0);
      chk("midrst.stuck", stuck, 0);
      idle(2);
      build_wave(100, -1, 1'b0);
      run_meas("after_rst", 103, 1'b0, 1'b0);

      // random waveforms against the reference model
      for (int k = 0; k < 30; k++) begin
         clear_wave();
         for (int t = 1; t < S - 3; t++) w[t] = 1'($urandom_range(0, 1));
         mode = $urandom_range(0, 7);
         if (mode == 0) begin
            th = S - 5 + $urandom_range(0, 6);
            for (int t = 0; t <= th; t++) w[t] = 1'b1;
         end
         th = $urandom_range(0, MAXC + 10);
         for (int t = S + 1 + th; t < NT; t++) w[t] = 1'b1;
         for (int g = 0; g < 3; g++)
            w[S + 1 + $urandom_range(0, MAXC)] = 1'b1;
         model(ec, eto, estk);
         td  = done_cycle(ec, estk);
         lim = estk ? td - 1 : td;
         for (int g = 0; g < 2; g++)
            st[$urandom_range(1, lim)] = 1'b1;
         run_meas("random", ec, eto, estk);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
